// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request, completion and RAM-side signals of the RAM arbiter.
// slave modport: the arbiter. It takes both requester ports and the RAM response,
// and drives the wait/load returns and the RAM command.
// master modport: the environment. It holds the fetch/data paths and the RAM model.
interface ram_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ramerr;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: grants the single RAM port to the instruction or the data path, with a watchdog timeout.
// Ports: CLK (rising edge), nRST (async, active low), bus (ram_arbiter_if.slave).
// Build option ARB_RR_EN: when defined, contention alternates between the ports; otherwise data always wins.
module ram_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic          CLK,
  input logic          nRST,
  ram_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] tMax = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;
  state_t state, nextState;
  logic [CW-1:0] waitCnt;
  logic iReq, dReq, granted, access, held;
  assign iReq = bus.iREN;
  assign dReq = bus.dREN | bus.dWEN;
  assign granted = state != IDLE;
  assign access = bus.ramstate == 2'd2;
  assign held = state == I_ACC ? iReq : dReq;
  assign bus.ramaddr = state == I_ACC ? bus.iaddr : state == D_ACC ? bus.daddr : '0;
  assign bus.ramstore = state == D_ACC ? bus.dstore : '0;
  assign bus.ramWEN = state == D_ACC & bus.dWEN;
  // A write wins when both data enables are set.
  assign bus.ramREN = state == I_ACC ? bus.iREN : state == D_ACC & bus.dREN & ~bus.dWEN;
  assign bus.iwait = ~(state == I_ACC & access);
  assign bus.dwait = ~(state == D_ACC & access);
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  // The abort fires only if the access is not completing in the same cycle.
  assign bus.ramerr = granted & ~access & waitCnt == tMax;
`ifdef ARB_RR_EN
  logic lastGrantD;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) lastGrantD <= 1'b1;
    else if (granted & access) lastGrantD <= state == D_ACC;
`endif
  always_comb begin
    nextState = state;
    if (state == IDLE) begin
`ifdef ARB_RR_EN
      nextState = dReq & iReq ? (lastGrantD ? I_ACC : D_ACC) : dReq ? D_ACC : iReq ? I_ACC : IDLE;
`else
      nextState = dReq ? D_ACC : iReq ? I_ACC : IDLE;
`endif
    end else if (access | bus.ramerr | ~held) nextState = IDLE;
  end
  // Grants are only entered from IDLE, so clearing in IDLE clears the counter on entry.
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      waitCnt <= state == IDLE ? '0 : (access | waitCnt == tMax) ? waitCnt : waitCnt + 1'b1;
    end
endmodule
